spi_mstr: RTL and testbench

// - 16-bit full-duplex SPI master; DSO digital core uses it to program AFE gain pots, trigger-level pot, read cal EEPROM.
// - One transaction per wrt pulse: shifts data_out MSB-first on MOSI, captures MISO into data_in, raises done.
// - Sits between dig_core (command side) and off-chip SPI slaves; SCLK derived from system clk.

---
 rtl/spi_mstr_if.sv | 57 +++++
 rtl/spi_mstr.sv | 167 ++++++++++++++++
 tb/tb_spi_mstr.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mstr_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_mstr_if
//  Purpose  : Command-side handshake and SPI pin bundle for spi_mstr.
//             The master modport is the spi_mstr view; the slave modport is
//             the view of whatever drives commands and models the SPI peer.
//             SPI_MSTR_SS_DECODE_EN adds the ss select code and the decoded
//             5-wide slave-select vector.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_mstr_if #(
    parameter int WIDTH = 16
);
    logic             wrt;
    logic [WIDTH-1:0] data_out;
    logic             MISO;
    logic             SCLK;
    logic             MOSI;
    logic             SS_n;
    logic             done;
    logic [WIDTH-1:0] data_in;
`ifdef SPI_MSTR_SS_DECODE_EN
    logic [2:0]       ss;
    logic [4:0]       ss_n_vec;
`endif

    modport master (
        input  wrt,
        input  data_out,
        input  MISO,
`ifdef SPI_MSTR_SS_DECODE_EN
        input  ss,
        output ss_n_vec,
`endif
        output SCLK,
        output MOSI,
        output SS_n,
        output done,
        output data_in
    );

    modport slave (
        output wrt,
        output data_out,
        output MISO,
`ifdef SPI_MSTR_SS_DECODE_EN
        output ss,
        input  ss_n_vec,
`endif
        input  SCLK,
        input  MOSI,
        input  SS_n,
        input  done,
        input  data_in
    );
endinterface
`default_nettype wire

// File: rtl/spi_mstr.sv
`default_nettype none
// ============================================================================
//  Module   : spi_mstr
//  Purpose  : Full-duplex SPI master (SCLK idle high, slave samples MOSI on
//             the rising edge and drives MISO on the falling edge). One
//             WIDTH-bit MSB-first transaction per accepted wrt pulse; done is
//             a level held until the next accepted wrt.
//             Optional macro SPI_MSTR_SS_DECODE_EN: latches a 3-bit slave
//             code on wrt and steers SS_n onto one of five select lines.
//  Revision : 1.0  initial release
// ============================================================================
module spi_mstr #(
    parameter int SCLK_DIV = 16,
    parameter int WIDTH    = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    spi_mstr_if.master bus
);

    localparam int c_div_w = $clog2(SCLK_DIV);
    localparam int c_bit_w = $clog2(WIDTH) + 1;

    // div_cnt values at which SCLK changes on the following clock edge
    localparam logic [c_div_w-1:0] c_half_end = c_div_w'(SCLK_DIV / 2 - 1);
    localparam logic [c_div_w-1:0] c_per_end  = c_div_w'(SCLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(WIDTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_porch = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_back  = 2'd3;

    logic [1:0]         state_q,     state_d;
    logic [c_div_w-1:0] div_cnt_q,   div_cnt_d;
    logic [c_bit_w-1:0] bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]   shift_reg_q, shift_reg_d;
    logic               miso_smp_q,  miso_smp_d;
    logic               sclk_q,      sclk_d;
    logic               ss_n_q,      ss_n_d;
    logic               done_q,      done_d;
`ifdef SPI_MSTR_SS_DECODE_EN
    logic [2:0]         ss_sel_q,    ss_sel_d;
    logic [4:0]         w_ss_n_vec;
`endif

    logic w_half_end;
    logic w_per_end;

    assign w_half_end = (div_cnt_q == c_half_end);
    assign w_per_end  = (div_cnt_q == c_per_end);

    // State register and all datapath flops; reset aborts any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_idle;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_reg_q <= '0;
            miso_smp_q  <= 1'b0;
            sclk_q      <= 1'b1;
            ss_n_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef SPI_MSTR_SS_DECODE_EN
            ss_sel_q    <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
            miso_smp_q  <= miso_smp_d;
            sclk_q      <= sclk_d;
            ss_n_q      <= ss_n_d;
            done_q      <= done_d;
`ifdef SPI_MSTR_SS_DECODE_EN
            ss_sel_q    <= ss_sel_d;
`endif
        end
    end

    // Next-state: half-period porch, WIDTH full periods, then the high half
    // of the last period as back porch before releasing the slave
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (bus.wrt) state_d = c_porch;
            c_porch: if (w_half_end) state_d = c_shift;
            c_shift: if (w_per_end && (bit_cnt_q == c_last_bit)) state_d = c_back;
            c_back:  if (w_half_end) state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    // Datapath: SCLK edges, MISO sampling on rise, shifting on each later fall
    always_comb begin
        // divider free-runs only while the slave is selected
        div_cnt_d   = ss_n_q ? '0 : (div_cnt_q + c_div_w'(1));
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        miso_smp_d  = miso_smp_q;
        sclk_d      = sclk_q;
        ss_n_d      = ss_n_q;
        done_d      = done_q;
`ifdef SPI_MSTR_SS_DECODE_EN
        ss_sel_d    = ss_sel_q;
`endif
        case (state_q)
            c_idle: begin
                if (bus.wrt) begin
                    shift_reg_d = bus.data_out;
                    done_d      = 1'b0;
                    ss_n_d      = 1'b0;
                    div_cnt_d   = '0;
                    bit_cnt_d   = '0;
`ifdef SPI_MSTR_SS_DECODE_EN
                    ss_sel_d    = bus.ss;
`endif
                end
            end
            c_porch: begin
                // first falling edge: slave puts out its MSB, nothing to shift yet
                if (w_half_end) sclk_d = 1'b0;
            end
            c_shift: begin
                if (w_per_end) begin
                    sclk_d     = 1'b1;
                    miso_smp_d = bus.MISO;
                    bit_cnt_d  = bit_cnt_q + c_bit_w'(1);
                end else if (w_half_end) begin
                    sclk_d      = 1'b0;
                    shift_reg_d = {shift_reg_q[WIDTH-2:0], miso_smp_q};
                end
            end
            c_back: begin
                // SCLK stays high; the last sampled bit is shifted in here
                if (w_half_end) begin
                    shift_reg_d = {shift_reg_q[WIDTH-2:0], miso_smp_q};
                    ss_n_d      = 1'b1;
                    done_d      = 1'b1;
                    div_cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef SPI_MSTR_SS_DECODE_EN
    // Route SS_n to the latched slave code; codes 5..7 select nobody
    always_comb begin
        w_ss_n_vec = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            if (ss_sel_q == 3'(i)) w_ss_n_vec[i] = ss_n_q;
        end
    end

    assign bus.ss_n_vec = w_ss_n_vec;
`endif

    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = shift_reg_q[WIDTH-1];
    assign bus.SS_n    = ss_n_q;
    assign bus.done    = done_q;
    assign bus.data_in = shift_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mstr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_mstr
//  Purpose  : Self-checking bench for spi_mstr. A behavioural SPI slave
//             (shift out on SCLK fall, sample on SCLK rise) plus expected
//             values derived from the transaction rules: the slave must see
//             the word sent, data_in must equal the word the slave returned,
//             and SS_n stays low SCLK_DIV/2 + WIDTH*SCLK_DIV cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_mstr;

    localparam int SCLK_DIV = 16;
    localparam int WIDTH    = 16;
    localparam int XFER_LEN = SCLK_DIV / 2 + WIDTH * SCLK_DIV;

    logic clk = 1'b0;
    logic rst;

    int n_total = 0;
    int n_bad   = 0;

    spi_mstr_if #(.WIDTH(WIDTH)) bus ();

    spi_mstr #(
        .SCLK_DIV (SCLK_DIV),
        .WIDTH    (WIDTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit system clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural SPI slave
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] slave_tx = '0;
    logic [WIDTH-1:0] slave_rx = '0;
    int slave_falls = 0;
    int slave_rises = 0;
    int ss_falls    = 0;
    int sclk_edges  = 0;

    // New selection restarts the slave's bit counters
    always @(negedge bus.SS_n) begin
        slave_falls = 0;
        slave_rises = 0;
        slave_rx    = '0;
        ss_falls++;
    end

    // Slave drives the next MISO bit on every falling SCLK while selected
    always @(negedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            if (slave_falls < WIDTH) bus.MISO = slave_tx[WIDTH-1-slave_falls];
            slave_falls++;
        end
    end

    // Slave samples MOSI on every rising SCLK while selected
    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            slave_rx = {slave_rx[WIDTH-2:0], bus.MOSI};
            slave_rises++;
        end
    end

    // Any SCLK transition, used to prove SCLK is quiet while idle
    always @(bus.SCLK) sclk_edges++;

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called between clock edges with the DUT idle; returns in cycle T0+1
    task automatic start_wrt(input logic [WIDTH-1:0] tx);
        bus.wrt      = 1'b1;
        bus.data_out = tx;
        @(posedge clk); #1;
        bus.wrt      = 1'b0;
        bus.data_out = WIDTH'($urandom);
    endtask

    // Runs from T0+1 until done; optionally pulses a stray wrt at T0+extra_at
    task automatic finish_xfer(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] sw,
                               input int extra_at, input string tag);
        int cyc;
        int low;
        cyc = 1;
        low = 0;
        check({tag, ".ssn_start"}, 32'(bus.SS_n), 32'd0);
        check({tag, ".done_drop"}, 32'(bus.done), 32'd0);
        check({tag, ".mosi_msb"},  32'(bus.MOSI), 32'(tx[WIDTH-1]));
        while (bus.done !== 1'b1 && cyc < XFER_LEN + 40) begin
            if (bus.SS_n === 1'b0) low++;
            bus.wrt      = (cyc == extra_at);
            bus.data_out = ~tx;
            @(posedge clk); #1;
            cyc++;
        end
        bus.wrt = 1'b0;
        check({tag, ".done_cycle"}, 32'(cyc), 32'(XFER_LEN + 1));
        check({tag, ".ssn_low"},    32'(low), 32'(XFER_LEN));
        check({tag, ".sclk_rises"}, 32'(slave_rises), 32'(WIDTH));
        check({tag, ".slave_rx"},   32'(slave_rx), 32'(tx));
        check({tag, ".data_in"},    32'(bus.data_in), 32'(sw));
        check({tag, ".ssn_end"},    32'(bus.SS_n), 32'd1);
    endtask

    // Idle for n cycles, returning the number of cycles SS_n was low
    task automatic idle_cycles(input int n, output int low);
        low = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.SS_n !== 1'b1) low++;
        end
    endtask

`ifdef SPI_MSTR_SS_DECODE_EN
    function automatic logic [4:0] exp_ss_vec(input logic [2:0] code);
        logic [4:0] v;
        v = 5'h1F;
        if (code < 3'd5) v[code] = 1'b0;
        return v;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int f0;
        int low;
        logic [WIDTH-1:0] tx;
        logic [WIDTH-1:0] sw;
        int extra;

        rst          = 1'b1;
        bus.wrt      = 1'b0;
        bus.data_out = '0;
`ifdef SPI_MSTR_SS_DECODE_EN
        bus.ss       = 3'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and quiet idle
        check("rst.ssn",     32'(bus.SS_n),    32'd1);
        check("rst.sclk",    32'(bus.SCLK),    32'd1);
        check("rst.done",    32'(bus.done),    32'd0);
        check("rst.mosi",    32'(bus.MOSI),    32'd0);
        check("rst.data_in", 32'(bus.data_in), 32'd0);
`ifdef SPI_MSTR_SS_DECODE_EN
        check("rst.ss_n_vec", 32'(bus.ss_n_vec), 32'h1F);
`endif
        sclk_edges = 0;
        idle_cycles(50, low);
        check("idle.sclk_edges", 32'(sclk_edges), 32'd0);
        check("idle.ssn_low",    32'(low),        32'd0);
        check("idle.done",       32'(bus.done),   32'd0);

        // Basic transfer
        slave_tx = 16'h0001;
        f0 = ss_falls;
        start_wrt(16'hA5C3);
        finish_xfer(16'hA5C3, 16'h0001, 0, "basic");
        check("basic.selects", 32'(ss_falls - f0), 32'd1);

        // Second wrt mid-transfer is ignored
        slave_tx = WIDTH'($urandom);
        sw = slave_tx;
        f0 = ss_falls;
        start_wrt(16'hFFFF);
        finish_xfer(16'hFFFF, sw, 100, "ignore");
        idle_cycles(20, low);
        check("ignore.idle_low", 32'(low), 32'd0);
        check("ignore.selects",  32'(ss_falls - f0), 32'd1);
        check("ignore.done_held", 32'(bus.done), 32'd1);

        // wrt presented in the cycle that makes done rise is ignored
        tx = WIDTH'($urandom);
        slave_tx = WIDTH'($urandom);
        sw = slave_tx;
        f0 = ss_falls;
        start_wrt(tx);
        finish_xfer(tx, sw, XFER_LEN, "edge");
        idle_cycles(3, low);
        check("edge.idle_low", 32'(low), 32'd0);
        check("edge.selects",  32'(ss_falls - f0), 32'd1);

        // Reset in the middle of a transfer
        slave_tx = WIDTH'($urandom);
        start_wrt(WIDTH'($urandom));
        repeat (119) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.ssn",     32'(bus.SS_n),    32'd1);
        check("midrst.sclk",    32'(bus.SCLK),    32'd1);
        check("midrst.done",    32'(bus.done),    32'd0);
        check("midrst.data_in", 32'(bus.data_in), 32'd0);
        slave_tx = WIDTH'($urandom);
        sw = slave_tx;
        start_wrt(16'h00FF);
        finish_xfer(16'h00FF, sw, 0, "after_rst");

        // Back-to-back with the slave echoing the master's word
        slave_tx = 16'h8001;
        start_wrt(16'h8001);
        finish_xfer(16'h8001, 16'h8001, 0, "b2b_1");
        slave_tx = 16'h7FFE;
        start_wrt(16'h7FFE);
        finish_xfer(16'h7FFE, 16'h7FFE, 0, "b2b_2");

        // Randomized transfers with random gaps and stray wrt pulses
        for (int i = 0; i < 6; i++) begin
            tx = WIDTH'($urandom);
            sw = WIDTH'($urandom);
            slave_tx = sw;
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, XFER_LEN)) : 0;
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            f0 = ss_falls;
            start_wrt(tx);
            finish_xfer(tx, sw, extra, $sformatf("rand%0d", i));
            check($sformatf("rand%0d.selects", i), 32'(ss_falls - f0), 32'd1);
        end

`ifdef SPI_MSTR_SS_DECODE_EN
        // Slave-select decode: code latched at wrt, later changes ignored
        for (int j = 0; j < 3; j++) begin
            logic [2:0] code;
            code = (j == 0) ? 3'd4 : ((j == 1) ? 3'd1 : 3'd6);
            bus.ss   = code;
            tx       = WIDTH'($urandom);
            slave_tx = WIDTH'($urandom);
            sw       = slave_tx;
            start_wrt(tx);
            bus.ss = 3'($urandom);
            check($sformatf("ssdec%0d.active", j), 32'(bus.ss_n_vec), 32'(exp_ss_vec(code)));
            finish_xfer(tx, sw, 0, $sformatf("ssdec%0d", j));
            check($sformatf("ssdec%0d.release", j), 32'(bus.ss_n_vec), 32'h1F);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
